// File: rtl/key_search_pkg.sv
// Shared definitions for the key-search scheduler and the cracking cores.
//   sched_state_t : scheduler sequencing states
//   KEY_WIDTH     : default key bus width
//   KEY_MAX       : default last valid key (inclusive)
package key_search_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DISPATCH,
    DRAIN,
    FOUND,
    EXHAUSTED
  } sched_state_t;

  localparam int                  KEY_WIDTH = 24;
  localparam logic [KEY_WIDTH-1:0] KEY_MAX  = 24'h3FFFFF;

endpackage

// File: rtl/key_search_scheduler_if.sv
// Bundle between the scheduler and the replicated cracking cores.
//   work_req   core -> sched  core i idle, wants a chunk (level)
//   core_busy  core -> sched  core i still searching its chunk
//   core_found core -> sched  core i matched (held until halt)
//   core_key   core -> sched  matching key of core i, slice i
//   work_gnt   sched -> core  one-hot single-cycle grant
//   work_base  sched -> core  chunk base, valid while work_gnt != 0
//   halt       sched -> core  stop searching (held)
interface key_search_scheduler_if #(
  parameter int NUM_CORES = 4,
  parameter int KEY_WIDTH = key_search_pkg::KEY_WIDTH
);
  logic [NUM_CORES-1:0]           work_req;
  logic [NUM_CORES-1:0]           core_busy;
  logic [NUM_CORES-1:0]           core_found;
  logic [NUM_CORES*KEY_WIDTH-1:0] core_key;
  logic [NUM_CORES-1:0]           work_gnt;
  logic [KEY_WIDTH-1:0]           work_base;
  logic                           halt;

  // scheduler side
  modport master (
    input  work_req, core_busy, core_found, core_key,
    output work_gnt, work_base, halt
  );

  // core side
  modport slave (
    output work_req, core_busy, core_found, core_key,
    input  work_gnt, work_base, halt
  );
endinterface

// File: rtl/key_search_scheduler_rr_arbiter.sv
// Combinational round-robin pick.
//   eligible    : requesters allowed to win this cycle
//   rr_ptr      : index searched first; search wraps modulo N
//   grant       : one-hot winner (zero when nothing eligible)
//   grant_idx   : index of the winner
//   grant_valid : a winner exists
// The pointer register itself lives in the caller.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] rr_ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  always_comb begin
    int idx;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(rr_ptr) + k) % N;
      if (!grant_valid && eligible[idx]) begin
        grant_valid    = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/key_search_scheduler.sv
// Sequencer for a parallel RC4 key search. Carves 0..KEY_MAX into
// 2**CHUNK_BITS-key chunks and deals them round-robin to the cores, stops
// everything on the first match, and reports exhaustion otherwise.
//   clok       : clock, posedge
//   resetm     : asynchronous active-low reset
//   start      : single-cycle pulse, begin/restart a search
//   cores      : core bundle (master side)
//   result_key : latched matching key
//   key_found  : search ended with a match (held)
//   exhausted  : search ended without a match (held)
//   LEDS       : {key_found, exhausted}
module key_search_scheduler #(
  parameter int                   NUM_CORES  = 4,
  parameter int                   KEY_WIDTH  = key_search_pkg::KEY_WIDTH,
  parameter logic [KEY_WIDTH-1:0] KEY_MAX    = key_search_pkg::KEY_MAX,
  parameter int                   CHUNK_BITS = 16
) (
  input  logic                  clok,
  input  logic                  resetm,
  input  logic                  start,
  key_search_scheduler_if.master cores,
  output logic [KEY_WIDTH-1:0]  result_key,
  output logic                  key_found,
  output logic                  exhausted,
  output logic [1:0]            LEDS
);
  import key_search_pkg::*;

  localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  // one extra bit so the running base can pass KEY_MAX without wrapping
  localparam logic [KEY_WIDTH:0] CHUNK = (KEY_WIDTH+1)'(1) << CHUNK_BITS;

  sched_state_t state_reg, state_next;

  logic [KEY_WIDTH:0]   next_base_reg, next_base_next;
  logic [IW-1:0]        rr_ptr_reg, rr_ptr_next;
  logic [NUM_CORES-1:0] work_gnt_reg, work_gnt_next;
  logic [KEY_WIDTH-1:0] work_base_reg, work_base_next;
  logic [KEY_WIDTH-1:0] result_key_reg, result_key_next;
  logic                 halt_reg, halt_next;
  logic                 key_found_reg, key_found_next;
  logic                 exhausted_reg, exhausted_next;

  logic [KEY_WIDTH-1:0] key_slice [NUM_CORES];
  logic [KEY_WIDTH-1:0] finder_key;
  logic [NUM_CORES-1:0] eligible, arb_gnt;
  logic [IW-1:0]        arb_idx;
  logic                 arb_valid, any_found, last_issue, drain_done;
  logic [KEY_WIDTH:0]   base_inc;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CORES; gi++) begin : g_slice
      assign key_slice[gi] = cores.core_key[gi*KEY_WIDTH +: KEY_WIDTH];
    end
  endgenerate

  // lowest-index finder wins when several cores match together
  always_comb begin
    finder_key = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (cores.core_found[i]) finder_key = key_slice[i];
    end
  end

  // a core still holds work_req in the cycle its grant is visible; masking
  // with the live grant keeps it from being served twice
  assign eligible   = cores.work_req & ~work_gnt_reg;
  assign any_found  = |cores.core_found;
  assign base_inc   = next_base_reg + CHUNK;
  assign last_issue = base_inc > {1'b0, KEY_MAX};
  // the last-granted core only raises core_busy the cycle after its grant,
  // so an outstanding grant also keeps the search alive
  assign drain_done = ~|cores.core_busy && ~|work_gnt_reg;

  rr_arbiter #(.N(NUM_CORES), .IW(IW)) u_arb (
    .eligible   (eligible),
    .rr_ptr     (rr_ptr_reg),
    .grant      (arb_gnt),
    .grant_idx  (arb_idx),
    .grant_valid(arb_valid)
  );

  // state register
  always_ff @(posedge clok or negedge resetm) begin
    if (!resetm) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, FOUND, EXHAUSTED: if (start) state_next = DISPATCH;
      DISPATCH: begin
        if (any_found)                    state_next = FOUND;
        else if (arb_valid && last_issue) state_next = DRAIN;
      end
      DRAIN: begin
        if (any_found)       state_next = FOUND;
        else if (drain_done) state_next = EXHAUSTED;
      end
      default: state_next = IDLE;
    endcase
  end

  // output / datapath next values
  always_comb begin
    next_base_next  = next_base_reg;
    rr_ptr_next     = rr_ptr_reg;
    work_gnt_next   = '0;
    work_base_next  = '0;
    result_key_next = result_key_reg;
    halt_next       = halt_reg;
    key_found_next  = key_found_reg;
    exhausted_next  = exhausted_reg;
    case (state_reg)
      IDLE, FOUND, EXHAUSTED: begin
        if (start) begin
          next_base_next  = '0;
          rr_ptr_next     = '0;
          result_key_next = '0;
          halt_next       = 1'b0;
          key_found_next  = 1'b0;
          exhausted_next  = 1'b0;
        end
      end
      DISPATCH, DRAIN: begin
        if (any_found) begin
          result_key_next = finder_key;
          halt_next       = 1'b1;
          key_found_next  = 1'b1;
        end else if (state_reg == DISPATCH) begin
          if (arb_valid) begin
            work_gnt_next  = arb_gnt;
            work_base_next = next_base_reg[KEY_WIDTH-1:0];
            next_base_next = base_inc;
            rr_ptr_next    = (arb_idx == IW'(NUM_CORES - 1)) ? '0 : arb_idx + 1'b1;
          end
        end else if (drain_done) begin
          exhausted_next = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clok or negedge resetm) begin
    if (!resetm) begin
      next_base_reg  <= '0;
      rr_ptr_reg     <= '0;
      work_gnt_reg   <= '0;
      work_base_reg  <= '0;
      result_key_reg <= '0;
      halt_reg       <= 1'b0;
      key_found_reg  <= 1'b0;
      exhausted_reg  <= 1'b0;
    end else begin
      next_base_reg  <= next_base_next;
      rr_ptr_reg     <= rr_ptr_next;
      work_gnt_reg   <= work_gnt_next;
      work_base_reg  <= work_base_next;
      result_key_reg <= result_key_next;
      halt_reg       <= halt_next;
      key_found_reg  <= key_found_next;
      exhausted_reg  <= exhausted_next;
    end
  end

  assign cores.work_gnt  = work_gnt_reg;
  assign cores.work_base = work_base_reg;
  assign cores.halt      = halt_reg;
  assign result_key      = result_key_reg;
  assign key_found       = key_found_reg;
  assign exhausted       = exhausted_reg;
  assign LEDS            = {key_found_reg, exhausted_reg};

endmodule
